countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter: the counting-down counterpart of the team's up-counting stopwatch. It takes a preset value, decrements it while enabled, and flags expiry when the value reaches zero. It sits alongside the stopwatch in the timing front end and shares the same start/pause control style. Its registered expiry outputs feed the alarm/LED logic downstream.

## Interface
- `WIDTH`, 4: count width in bits.
- `TICK_DIV`, 1: enabled clock cycles per decrement; must be ≥ 1.

- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `reset_n`, in, 1: reset is asynchronous and active-low.
- `load`, in, 1: preset strobe, sampled each edge.
- `load_val`, in, WIDTH: preset value, captured when `load`=1.
- `start`, in, 1: level enable; counting requires `start`=1.
- `pause`, in, 1: level freeze; while 1, the count and the prescaler hold.
- `count`, out, WIDTH: current remaining value, registered.
- `running`, out, 1: high while state is RUN, registered.
- `expired`, out, 1: high while state is DONE, registered.
- `done_pulse`, out, 1: single-cycle pulse on entry to DONE, registered.

## Operation
- States: IDLE, RUN, DONE.
- Prescaler `div` has width clog2(TICK_DIV), minimum 1 bit.
- A tick occurs when the state is RUN, `start`=1, `pause`=0, and `div`==TICK_DIV-1.
- Priority at each edge: reset_n, then load, then the state transitions below.

- Any state with `load`=1:
  - `count`←load_val, `div`←0, next state IDLE, `done_pulse`←0.
  - `start` and `pause` are ignored on that edge.

- IDLE:
  - `start`=1, `pause`=0, `count`≠0 → RUN, `div`←0, no decrement on this edge.
  - `start`=1, `pause`=0, `count`==0 → DONE, `done_pulse`←1.
  - Otherwise hold.

- RUN:
  - `start`=0 → IDLE; `count` holds, `div`←0.
  - `pause`=1 → hold `count` and `div`; stay RUN.
  - Enabled, no tick → `div`←div+1.
  - Tick with `count`>1 → `count`←count-1, `div`←0.
  - Tick with `count`==1 → `count`←0, DONE, `done_pulse`←1.

- DONE:
  - `count` stays 0; `start` and `pause` are ignored.
  - Exits only via `load`.
  - `done_pulse` deasserts after one cycle; `expired` stays high.

- No underflow: `count` never wraps below 0.
- Arithmetic is unsigned, WIDTH bits; the maximum preset is 2^WIDTH-1.

## Timing
- Reset values: state IDLE, `count`=0, `div`=0, `running`=0, `expired`=0, `done_pulse`=0.
- Reset asserted mid-run forces these values immediately, asynchronously.
- Reset release is synchronous to `clk`.
- All outputs are registered and change only on the `clk` edge (or on reset).
- With TICK_DIV=1:
  - Start sampled at edge 0 → RUN at edge 0.
  - First decrement at edge 1.
  - Preset N expires at edge N: `done_pulse` high during cycle N.
- General case: preset N expires TICK_DIV·N enabled cycles after entering RUN.
  - Pause cycles add a delay equal to their count.
- `load` in the same cycle as a tick: the load wins and the tick is lost.

## Structure
- Package `timer_pkg` holds:
  - The state enum (IDLE/RUN/DONE).
  - The default WIDTH and TICK_DIV constants.
- Sub-module `tick_prescaler`, parameterised by TICK_DIV:
  - Inputs: `clk`, `reset_n`, `clr`, `en`.
  - Output: `tick`.
  - Owns `div`.
- The top level owns the FSM, `count`, and the output registers.

## Test plan
- TICK_DIV=1, load 5, start held:
  - `count` goes 5,4,3,2,1,0 on edges 1–5.
  - `done_pulse` high for exactly one cycle; `expired` stays 1; `running` falls on the same edge.
- TICK_DIV=3, load 2, start held:
  - Decrements after 3 and 6 enabled cycles.
  - Assert `pause` for 4 cycles mid-count: expiry shifts by exactly 4 cycles.
- Load 0, then assert start:
  - DONE next edge with `done_pulse`=1.
  - `count` stays 0 and never wraps to 15.
- Load 9, run to 6, drop `start`:
  - IDLE with `count`=6 held.
  - Re-raise `start`: resumes from 6; first decrement TICK_DIV cycles after re-entering RUN.
- In DONE, assert `load` with `load_val`=3:
  - IDLE, `count`=3, `expired`=0.
  - `load` asserted together with a tick during RUN: `count`=load_val, no decrement.
- Pull `reset_n` low mid-run with `count`=7:
  - All outputs go to 0 and the state to IDLE without a clock edge.
  - After release, holds until the next start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer.
//   state_t      : controller states (IDLE / RUN / DONE)
//   TP_WIDTH     : default count width in bits
//   TP_TICK_DIV  : default enabled clock cycles per decrement
//   div_width()  : prescaler register width, clog2(n) with a 1-bit floor
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned TP_WIDTH    = 4;
    localparam int unsigned TP_TICK_DIV = 1;

    function automatic int unsigned div_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles down to one tick every TICK_DIV cycles.
//   clk     in  : clock, rising edge
//   reset_n in  : asynchronous active-low reset
//   clr     in  : synchronous clear of the divider (priority over en)
//   en      in  : count enable; the divider holds while low
//   tick    out : high in the enabled cycle where the divider is at TICK_DIV-1
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TP_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     DW   = div_width(TICK_DIV);
    localparam logic [DW-1:0]   LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] r_div;
    logic          w_at_last;

    assign w_at_last = (r_div == LAST);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (clr) begin
            r_div <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause control and registered expiry flags.
//   clk        in  : clock, rising edge
//   reset_n    in  : asynchronous active-low reset
//   load       in  : preset strobe (highest priority after reset)
//   load_val   in  : preset value captured on load
//   start      in  : level enable for counting
//   pause      in  : level freeze of count and prescaler
//   count      out : remaining value
//   running    out : state is RUN
//   expired    out : state is DONE
//   done_pulse out : one-cycle pulse on entry to DONE
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = TP_WIDTH,
    parameter int unsigned TICK_DIV = TP_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done_pulse
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             r_expired;
    logic             r_done_pulse;

    logic w_en;
    logic w_clr;
    logic w_tick;

    // The divider only advances while actually counting; any exit from that
    // condition (load, leaving RUN, dropping start) restarts it from zero.
    // Pause is neither, so the divider holds its phase across a pause.
    assign w_en  = (r_state == ST_RUN) && start && !pause && !load;
    assign w_clr = load || (r_state != ST_RUN) || !start;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_clr),
        .en      (w_en),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_running    <= 1'b0;
            r_expired    <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (load) begin
                r_state   <= ST_IDLE;
                r_count   <= load_val;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !pause) begin
                            if (r_count != '0) begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end else begin
                                r_state      <= ST_DONE;
                                r_expired    <= 1'b1;
                                r_done_pulse <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!start) begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            // RUN is only entered with a non-zero count, so
                            // the last tick lands on 1 and never wraps.
                            if (r_count == WIDTH'(1)) begin
                                r_count      <= '0;
                                r_state      <= ST_DONE;
                                r_running    <= 1'b0;
                                r_expired    <= 1'b1;
                                r_done_pulse <= 1'b1;
                            end else begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_count <= '0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        r_expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count      = r_count;
    assign running    = r_running;
    assign expired    = r_expired;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic         a_load, a_start, a_pause;
    logic [W-1:0] a_val;
    logic [W-1:0] a_count;
    logic         a_running, a_expired, a_done;

    logic         b_load, b_start, b_pause;
    logic [W-1:0] b_val;
    logic [W-1:0] b_count;
    logic         b_running, b_expired, b_done;

    countdown_timer #(.WIDTH(W), .TICK_DIV(1)) u_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (a_load),
        .load_val   (a_val),
        .start      (a_start),
        .pause      (a_pause),
        .count      (a_count),
        .running    (a_running),
        .expired    (a_expired),
        .done_pulse (a_done)
    );

    countdown_timer #(.WIDTH(W), .TICK_DIV(3)) u_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (b_load),
        .load_val   (b_val),
        .start      (b_start),
        .pause      (b_pause),
        .count      (b_count),
        .running    (b_running),
        .expired    (b_expired),
        .done_pulse (b_done)
    );

    typedef struct {
        logic         ld;
        logic [W-1:0] val;
        logic         st;
        logic         ps;
        logic [W-1:0] cnt;
        logic         run;
        logic         exp;
        logic         dp;
    } vec_t;

    typedef struct {
        string        name;
        bit           on_b;
        logic [W-1:0] cnt;
        logic         run;
        logic         exp;
        logic         dp;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string name, input bit on_b, input logic [W-1:0] cnt,
                            input logic run, input logic exp, input logic dp);
        exp_t e;
        e.name = name; e.on_b = on_b; e.cnt = cnt; e.run = run; e.exp = exp; e.dp = dp;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        logic [W+2:0] got, want;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb.pop_front();
        if (e.on_b) got = {b_count, b_running, b_expired, b_done};
        else        got = {a_count, a_running, a_expired, a_done};
        want = {e.cnt, e.run, e.exp, e.dp};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d run=%b exp=%b dp=%b, want cnt=%0d run=%b exp=%b dp=%b",
                     e.name, got[W+2:3], got[2], got[1], got[0],
                     e.cnt, e.run, e.exp, e.dp);
        end
    endtask

    task automatic step_a(input logic ld, input logic [W-1:0] val, input logic st, input logic ps,
                          input string name, input logic [W-1:0] cnt,
                          input logic run, input logic exp, input logic dp);
        a_load = ld; a_val = val; a_start = st; a_pause = ps;
        push_exp(name, 1'b0, cnt, run, exp, dp);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic step_b(input logic ld, input logic [W-1:0] val, input logic st, input logic ps,
                          input string name, input logic [W-1:0] cnt,
                          input logic run, input logic exp, input logic dp);
        b_load = ld; b_val = val; b_start = st; b_pause = ps;
        push_exp(name, 1'b1, cnt, run, exp, dp);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        //                ld val st ps   cnt run exp dp
        // load 5, count down to expiry, DONE ignores start/pause
        tv.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd2,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0});
        // load 0 then start: immediate DONE, no wrap
        tv.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0});
        // load 3 from DONE, start ignored on the load edge
        tv.push_back('{1'b1, 4'd3,  1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0});
        // load 9, run to 6, drop start, resume
        tv.push_back('{1'b1, 4'd9,  1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd9,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd8,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0});
        // pause freezes count
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0});
        // load on a tick edge wins; pause blocks IDLE->RUN
        tv.push_back('{1'b1, 4'd12, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0});
        // maximum preset
        tv.push_back('{1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0});

        reset_n = 1'b0;
        a_load = 1'b0; a_val = '0; a_start = 1'b0; a_pause = 1'b0;
        b_load = 1'b0; b_val = '0; b_start = 1'b0; b_pause = 1'b0;
        #12;
        push_exp("reset_a", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_front();
        push_exp("reset_b", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check_front();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            step_a(tv[i].ld, tv[i].val, tv[i].st, tv[i].ps, $sformatf("vecA[%0d]", i),
                   tv[i].cnt, tv[i].run, tv[i].exp, tv[i].dp);
        end

        // TICK_DIV=3, load 2: decrements after 3 and 6 enabled cycles
        step_b(1'b1, 4'd2, 1'b0, 1'b0, "b1_load", 4'd2, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b1_enter", 4'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step_b(1'b0, 4'd0, 1'b1, 1'b0, $sformatf("b1_k%0d", k),
                   (k < 3) ? 4'd2 : (k < 6) ? 4'd1 : 4'd0,
                   k < 6, k == 6, k == 6);
        end
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b1_after", 4'd0, 1'b0, 1'b1, 1'b0);

        // TICK_DIV=3, load 2, four pause cycles: expiry moves from 6 to 10
        step_b(1'b1, 4'd2, 1'b0, 1'b0, "b2_load", 4'd2, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b2_enter", 4'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step_b(1'b0, 4'd0, 1'b1, (k >= 2 && k <= 5), $sformatf("b2_k%0d", k),
                   (k < 7) ? 4'd2 : (k < 10) ? 4'd1 : 4'd0,
                   k < 10, k == 10, k == 10);
        end

        // TICK_DIV=3, load 9, run to 6, drop start, resume, then load on a tick edge
        step_b(1'b1, 4'd9, 1'b0, 1'b0, "b3_load", 4'd9, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_enter", 4'd9, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step_b(1'b0, 4'd0, 1'b1, 1'b0, $sformatf("b3_k%0d", k),
                   4'(9 - k / 3), 1'b1, 1'b0, 1'b0);
        end
        step_b(1'b0, 4'd0, 1'b0, 1'b0, "b3_stop", 4'd6, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_reenter", 4'd6, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_r1", 4'd6, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_r2", 4'd6, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_r3", 4'd5, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_r4", 4'd5, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_r5", 4'd5, 1'b1, 1'b0, 1'b0);
        step_b(1'b1, 4'd4, 1'b1, 1'b0, "b3_load_tick", 4'd4, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 4'd0, 1'b1, 1'b0, "b3_restart", 4'd4, 1'b1, 1'b0, 1'b0);

        // asynchronous reset mid-run with count 7
        step_a(1'b1, 4'd7, 1'b0, 1'b0, "rst_load7", 4'd7, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 4'd0, 1'b1, 1'b0, "rst_run7", 4'd7, 1'b1, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        push_exp("rst_async_a", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_front();
        push_exp("rst_async_b", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check_front();
        a_start = 1'b0;
        b_start = 1'b0;
        #2;
        reset_n = 1'b1;
        step_a(1'b0, 4'd0, 1'b0, 1'b0, "rst_hold1", 4'd0, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 4'd0, 1'b0, 1'b0, "rst_hold2", 4'd0, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 4'd0, 1'b1, 1'b0, "rst_start", 4'd0, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
